// File: rtl/mrc_scheduler.sv
// ============================================================================
// mrc_scheduler
// ----------------------------------------------------------------------------
// Round-robin scheduler that shares one multiply / square-root arithmetic unit
// between two requesters. A requester presents a complete operation (op select,
// operand A, operand B) and holds req_valid until it sees its req_accept pulse.
// The scheduler then drives the unit's start/load handshake, waits for the
// unit's ready pulse, and returns result/error to the owner with a done pulse.
//
// Parameters
//   WORD_LENGTH     operand width; result width is 2*WORD_LENGTH
//   TIMEOUT_CYCLES  watchdog limit per wait state (must be 1..255); only
//                   meaningful when MRC_SCHED_TIMEOUT_EN is defined
//
// Optional feature
//   MRC_SCHED_TIMEOUT_EN  when defined, an 8-bit watchdog aborts any of the
//                         WAIT_X / WAIT_Y / WAIT_RDY states after
//                         TIMEOUT_CYCLES cycles and completes the operation
//                         with result = 0 and result_error = 1.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   req_valid[1:0]          per-requester request, held until accepted
//   req_op0 / req_op1       op select per requester: 0 = multiply, 1 = sqrt
//   req_a0/req_b0, req_a1/req_b1   operands A and B per requester
//   req_accept[1:0]         one-hot, one-cycle pulse: operands captured
//   done[1:0]               one-hot, one-cycle pulse to the owner
//   result, result_error    outcome, held from done until the next done
//   busy                    high from accept through done
//   mrc_start, mrc_load     start / load pulses to the unit
//   mrc_data, mrc_op        operand and op select to the unit
//   mrc_x, mrc_y            unit ready for first / second operand
//   mrc_ready, mrc_result,  unit result-valid pulse, result and error flag
//   mrc_error
// ============================================================================
module mrc_scheduler #(
    parameter int WORD_LENGTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    input  logic                       req_op0,
    input  logic                       req_op1,
    input  logic [WORD_LENGTH-1:0]     req_a0,
    input  logic [WORD_LENGTH-1:0]     req_b0,
    input  logic [WORD_LENGTH-1:0]     req_a1,
    input  logic [WORD_LENGTH-1:0]     req_b1,
    output logic [1:0]                 req_accept,
    output logic [1:0]                 done,
    output logic [2*WORD_LENGTH-1:0]   result,
    output logic                       result_error,
    output logic                       busy,
    output logic                       mrc_start,
    output logic                       mrc_load,
    output logic [WORD_LENGTH-1:0]     mrc_data,
    output logic                       mrc_op,
    input  logic                       mrc_x,
    input  logic                       mrc_y,
    input  logic                       mrc_ready,
    input  logic [2*WORD_LENGTH-1:0]   mrc_result,
    input  logic                       mrc_error
);

    typedef enum logic [3:0] {
        IDLE,
        ACCEPT,
        START,
        WAIT_X,
        LOAD_X,
        WAIT_Y,
        LOAD_Y,
        WAIT_RDY,
        DONE
    } stateT;

    stateT                      state_q, state_d;
    logic                       grant_q, grant_d;
    logic                       pointer_q, pointer_d;
    logic                       op_q, op_d;
    logic [WORD_LENGTH-1:0]     operandA_q, operandA_d;
    logic [WORD_LENGTH-1:0]     operandB_q, operandB_d;
    logic [2*WORD_LENGTH-1:0]   result_q, result_d;
    logic                       resultError_q, resultError_d;
    logic                       timeoutHit;

`ifdef MRC_SCHED_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] watchdog_q, watchdog_d;
    logic       inWait;

    // The watchdog restarts from zero on every state change, so each wait
    // state gets its own full budget. It fires on the last counted cycle,
    // which makes the abort land after exactly TIMEOUT_CYCLES cycles.
    assign inWait     = (state_q == WAIT_X) || (state_q == WAIT_Y) ||
                        (state_q == WAIT_RDY);
    assign timeoutHit = inWait && (watchdog_q == TIMEOUT_LIMIT);

    always_comb begin
        watchdog_d = watchdog_q;
        if (state_d != state_q) begin
            watchdog_d = '0;
        end else if (inWait) begin
            watchdog_d = watchdog_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            watchdog_q <= '0;
        end else begin
            watchdog_q <= watchdog_d;
        end
    end
`else
    // Without the watchdog the wait states simply wait for the unit.
    assign timeoutHit = 1'b0;
`endif

    // State and datapath registers. Everything clears on reset so that an
    // operation interrupted by reset leaves no trace and is not replayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            pointer_q     <= 1'b0;
            op_q          <= 1'b0;
            operandA_q    <= '0;
            operandB_q    <= '0;
            result_q      <= '0;
            resultError_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            pointer_q     <= pointer_d;
            op_q          <= op_d;
            operandA_q    <= operandA_d;
            operandB_q    <= operandB_d;
            result_q      <= result_d;
            resultError_q <= resultError_d;
        end
    end

    // Next-state and Moore outputs. The operands of the granted requester are
    // captured on the edge that leaves IDLE, so they are already stable in the
    // register during the ACCEPT cycle; the accept pulse then tells the
    // requester it may change its inputs or drop its request.
    always_comb begin
        logic pick;

        state_d       = state_q;
        grant_d       = grant_q;
        pointer_d     = pointer_q;
        op_d          = op_q;
        operandA_d    = operandA_q;
        operandB_d    = operandB_q;
        result_d      = result_q;
        resultError_d = resultError_q;
        pick          = 1'b0;

        req_accept    = 2'b00;
        done          = 2'b00;
        busy          = 1'b1;
        mrc_start     = 1'b0;
        mrc_load      = 1'b0;
        mrc_data      = '0;
        mrc_op        = op_q;

        case (state_q)
            IDLE: begin
                busy   = 1'b0;
                mrc_op = 1'b0;
                if (req_valid != 2'b00) begin
                    // Contention goes to the pointer side; a lone request is
                    // granted regardless of whose turn it is.
                    if (req_valid == 2'b11) begin
                        pick = pointer_q;
                    end else begin
                        pick = req_valid[1];
                    end
                    grant_d    = pick;
                    op_d       = pick ? req_op1 : req_op0;
                    operandA_d = pick ? req_a1  : req_a0;
                    operandB_d = pick ? req_b1  : req_b0;
                    state_d    = ACCEPT;
                end
            end

            ACCEPT: begin
                mrc_op              = 1'b0;
                req_accept[grant_q] = 1'b1;
                state_d             = START;
            end

            START: begin
                mrc_start = 1'b1;
                state_d   = WAIT_X;
            end

            WAIT_X: begin
                if (mrc_x) begin
                    state_d = LOAD_X;
                end else if (timeoutHit) begin
                    result_d      = '0;
                    resultError_d = 1'b1;
                    state_d       = DONE;
                end
            end

            LOAD_X: begin
                mrc_load = 1'b1;
                mrc_data = operandA_q;
                // Square root has a single operand and skips the Y phase.
                state_d  = op_q ? WAIT_RDY : WAIT_Y;
            end

            WAIT_Y: begin
                if (mrc_y) begin
                    state_d = LOAD_Y;
                end else if (timeoutHit) begin
                    result_d      = '0;
                    resultError_d = 1'b1;
                    state_d       = DONE;
                end
            end

            LOAD_Y: begin
                mrc_load = 1'b1;
                mrc_data = operandB_q;
                state_d  = WAIT_RDY;
            end

            WAIT_RDY: begin
                // A ready pulse in the same cycle as the watchdog expiring
                // still delivers the real result.
                if (mrc_ready) begin
                    result_d      = mrc_result;
                    resultError_d = mrc_error;
                    state_d       = DONE;
                end else if (timeoutHit) begin
                    result_d      = '0;
                    resultError_d = 1'b1;
                    state_d       = DONE;
                end
            end

            DONE: begin
                done[grant_q] = 1'b1;
                pointer_d     = ~grant_q;
                state_d       = IDLE;
            end

            default: begin
                busy    = 1'b0;
                mrc_op  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign result       = result_q;
    assign result_error = resultError_q;

endmodule
